// File: rtl/vend_admin_ctrl.sv
// Admin and inventory controller: per-slot item counts, password-gated restock
// session with lockout and inactivity timeout, and a user-side vend port.
module vend_admin_ctrl #(
    parameter int                 NUM_SLOTS      = 69,
    parameter int                 IDX_W          = 7,
    parameter int                 CNT_W          = 4,
    parameter int                 MAX_COUNT      = 9,
    parameter int                 INIT_COUNT     = 9,
    parameter int                 PASS_W         = 2,
    parameter logic [PASS_W-1:0]  ADMIN_PASS     = 2'b10,
    parameter int                 MAX_TRIES      = 3,
    parameter int                 TIMEOUT_CYCLES = 2400000,
    parameter int                 LOCKOUT_CYCLES = 2400000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic [PASS_W-1:0] pass_idx,
    input  logic              up,
    input  logic              down,
    input  logic              confirm,
    input  logic              cancel,
    input  logic              vend_req,
    input  logic [IDX_W-1:0]  vend_idx,
    output logic              vend_ack,
    output logic              vend_fail,
    output logic              admin_mode,
    output logic              back_user,
    output logic              locked,
    output logic [IDX_W-1:0]  sseg_idx,
    output logic [CNT_W-1:0]  sseg_count
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CHECK_PASS = 3'd1;
    localparam logic [2:0] ST_SEL_SLOT   = 3'd2;
    localparam logic [2:0] ST_EDIT_COUNT = 3'd3;
    localparam logic [2:0] ST_COMMIT     = 3'd4;
    localparam logic [2:0] ST_LOCKOUT    = 3'd5;

    localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] TRIES    = FAIL_W'(MAX_TRIES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]  INIT_CNT = CNT_W'(INIT_COUNT);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  edit_q, edit_d;
    logic [CNT_W-1:0]  disp_q, disp_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [3:0]        btn_s1_q, btn_s1_d;
    logic [3:0]        btn_s2_q, btn_s2_d;
    logic              back_user_q, back_user_d;
    logic              vend_ack_q, vend_ack_d;
    logic              vend_fail_q, vend_fail_d;
    logic [CNT_W-1:0]  counts_q [NUM_SLOTS];
    logic [CNT_W-1:0]  counts_d [NUM_SLOTS];

    logic [3:0]       btn_edge;
    logic             e_up, e_dn, e_confirm, e_cancel, any_edge, step_up, step_dn;
    logic [IDX_W-1:0] vend_slot;
    logic             user_side;

    // Buttons are registered once, then compared with the previous sample.
    assign btn_s1_d  = {cancel, confirm, down, up};
    assign btn_s2_d  = btn_s1_q;
    assign btn_edge  = btn_s1_q & ~btn_s2_q;
    assign e_up      = btn_edge[0];
    assign e_dn      = btn_edge[1];
    assign e_confirm = btn_edge[2];
    assign e_cancel  = btn_edge[3];
    assign any_edge  = |btn_edge;
    assign step_up   = e_up & ~e_dn;
    assign step_dn   = e_dn & ~e_up;

    assign admin_mode = (state_q == ST_SEL_SLOT) || (state_q == ST_EDIT_COUNT) ||
                        (state_q == ST_COMMIT);
    assign locked     = (state_q == ST_LOCKOUT);
    assign user_side  = !admin_mode && !locked;
    assign vend_slot  = (vend_idx <= LAST_IDX) ? vend_idx : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        edit_d      = edit_q;
        fail_d      = fail_q;
        tmr_d       = tmr_q;
        back_user_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                tmr_d = '0;
                if (ready) state_d = ST_CHECK_PASS;
            end
            ST_CHECK_PASS: begin
                tmr_d = '0;
                if (e_cancel) begin
                    state_d = ST_IDLE;
                end else if (e_confirm) begin
                    if (pass_idx == ADMIN_PASS) begin
                        state_d = ST_SEL_SLOT;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_q + FAIL_W'(1) == TRIES) state_d = ST_LOCKOUT;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == LCK_LAST) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SEL_SLOT, ST_EDIT_COUNT: begin
                // Timeout wins over any button edge in the same cycle.
                if (tmr_q == TMO_LAST) begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    tmr_d       = '0;
                    back_user_d = 1'b1;
                end else begin
                    tmr_d = any_edge ? '0 : tmr_q + TMR_W'(1);
                    if (state_q == ST_SEL_SLOT) begin
                        if (e_cancel) begin
                            state_d     = ST_IDLE;
                            idx_d       = '0;
                            back_user_d = 1'b1;
                        end else if (e_confirm) begin
                            state_d = ST_EDIT_COUNT;
                            edit_d  = counts_q[idx_q];
                        end else if (step_up) begin
                            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        end else if (step_dn) begin
                            idx_d = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
                        end
                    end else begin
                        if (e_cancel) begin
                            state_d = ST_SEL_SLOT;
                        end else if (e_confirm) begin
                            state_d = ST_COMMIT;
                        end else if (step_up) begin
                            if (edit_q != MAX_CNT) edit_d = edit_q + CNT_W'(1);
                        end else if (step_dn) begin
                            if (edit_q != '0) edit_d = edit_q - CNT_W'(1);
                        end
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_SEL_SLOT;
                tmr_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Count updates: admin commit and user vend are mutually exclusive by state.
    always_comb begin
        counts_d    = counts_q;
        vend_ack_d  = 1'b0;
        vend_fail_d = 1'b0;
        if (state_q == ST_COMMIT) counts_d[idx_q] = edit_q;
        if (vend_req) begin
            if (user_side && (vend_idx <= LAST_IDX) && (counts_q[vend_slot] != '0)) begin
                counts_d[vend_slot] = counts_q[vend_slot] - CNT_W'(1);
                vend_ack_d          = 1'b1;
            end else begin
                vend_fail_d = 1'b1;
            end
        end
    end

    assign disp_d = ((state_q == ST_EDIT_COUNT) || (state_q == ST_COMMIT)) ? edit_q
                                                                          : counts_q[idx_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            edit_q      <= '0;
            disp_q      <= '0;
            fail_q      <= '0;
            tmr_q       <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            back_user_q <= 1'b0;
            vend_ack_q  <= 1'b0;
            vend_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            edit_q      <= edit_d;
            disp_q      <= disp_d;
            fail_q      <= fail_d;
            tmr_q       <= tmr_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            back_user_q <= back_user_d;
            vend_ack_q  <= vend_ack_d;
            vend_fail_q <= vend_fail_d;
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst_n) counts_q[gi] <= INIT_CNT;
            else        counts_q[gi] <= counts_d[gi];
        end
    end

    assign vend_ack   = vend_ack_q;
    assign vend_fail  = vend_fail_q;
    assign back_user  = back_user_q;
    assign sseg_idx   = idx_q;
    assign sseg_count = admin_mode ? disp_q : '0;

endmodule

// File: tb/tb_vend_admin_ctrl.sv
// Directed self-checking bench for vend_admin_ctrl with short timeout/lockout.
module tb_vend_admin_ctrl;

    localparam int TMO = 80;
    localparam int LCK = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] pass_idx = 2'b00;
    logic       up = 1'b0, down = 1'b0, confirm = 1'b0, cancel = 1'b0;
    logic       vend_req = 1'b0;
    logic [6:0] vend_idx = '0;
    logic       vend_ack, vend_fail, admin_mode, back_user, locked;
    logic [6:0] sseg_idx;
    logic [3:0] sseg_count;

    int errors = 0;
    int checks = 0;

    vend_admin_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .LOCKOUT_CYCLES(LCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .pass_idx(pass_idx),
        .up(up), .down(down), .confirm(confirm), .cancel(cancel),
        .vend_req(vend_req), .vend_idx(vend_idx),
        .vend_ack(vend_ack), .vend_fail(vend_fail), .admin_mode(admin_mode),
        .back_user(back_user), .locked(locked),
        .sseg_idx(sseg_idx), .sseg_count(sseg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: confirm = v;
            default: cancel = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk); set_btn(b, 1'b1);
        repeat (2) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic press_n(input int b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic login;
        ready = 1'b1; pass_idx = 2'b10;
        repeat (3) @(negedge clk);
        press(2);
        ready = 1'b0;
    endtask

    task automatic vend(input int slot, output int res);
        @(negedge clk); vend_req = 1'b1; vend_idx = 7'(slot);
        @(negedge clk); vend_req = 1'b0;
        res = {30'd0, vend_ack, vend_fail};
    endtask

    initial begin
        int res, tcyc, bad, lk, adm;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_admin", admin_mode, 0);
        check("rst_locked", locked, 0);
        check("rst_idx", sseg_idx, 0);
        check("rst_count", sseg_count, 0);
        check("rst_ack_fail_back", {vend_ack, vend_fail, back_user}, 0);

        login();
        check("login_admin", admin_mode, 1);
        check("login_idx", sseg_idx, 0);
        check("login_count", sseg_count, 9);

        // Restock slot 68 reached by wrapping down from 0
        press(1);
        check("wrap_down_idx", sseg_idx, 68);
        press(2); press_n(1, 4);
        check("edit_down4", sseg_count, 5);
        press(2);
        check("commit_idx", sseg_idx, 68);
        check("commit_count", sseg_count, 5);
        press(2); press_n(0, 10);
        check("edit_sat_max", sseg_count, 9);
        press(3);
        check("cancel_keeps", sseg_count, 5);
        press(0);
        check("wrap_up_idx", sseg_idx, 0);

        // Simultaneous up+down, then a long hold
        @(negedge clk); up = 1'b1; down = 1'b1;
        repeat (3) @(negedge clk); up = 1'b0; down = 1'b0;
        repeat (3) @(negedge clk);
        check("simul_updown", sseg_idx, 0);
        @(negedge clk); up = 1'b1;
        repeat (50) @(negedge clk); up = 1'b0;
        repeat (3) @(negedge clk);
        check("held_up", sseg_idx, 1);

        // Cancel then timeout on slot 3
        press_n(0, 2);
        check("sel_slot3", sseg_idx, 3);
        press(2); press_n(1, 7);
        check("edit_to_2", sseg_count, 2);
        press(3);
        check("cancel_slot3", sseg_count, 9);
        press(2); press(1);
        check("edit_to_8", sseg_count, 8);
        tcyc = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (back_user) begin tcyc = c; break; end
        end
        check("timeout_cycle", tcyc, TMO - 4);
        check("timeout_admin", admin_mode, 0);
        @(negedge clk);
        check("back_user_1cyc", back_user, 0);
        login();
        press_n(0, 3);
        check("timeout_slot3", sseg_count, 9);
        press(3);
        check("exit_admin", admin_mode, 0);

        // Vend port
        for (int i = 0; i < 10; i++) begin
            vend(5, res);
            check($sformatf("vend5_%0d", i), res, (i < 9) ? 2 : 1);
        end
        vend(100, res);
        check("vend_idx100", res, 1);
        login();
        vend(7, res);
        check("vend_in_admin", res, 1);
        press_n(0, 5);
        check("slot5_empty", sseg_count, 0);
        press_n(0, 2);
        check("slot7_unchanged", sseg_count, 9);

        // Reset during edit
        press(2); press(1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_edit_admin", admin_mode, 0);
        check("rst_edit_idx", sseg_idx, 0);
        bad = 0;
        for (int i = 0; i < 69; i++) if (dut.counts_q[i] != 4'd9) bad++;
        check("rst_counts_bad", bad, 0);

        // Lockout
        ready = 1'b1; pass_idx = 2'b01;
        repeat (3) @(negedge clk);
        press_n(2, 2);
        check("two_wrong_unlocked", locked, 0);
        @(negedge clk); confirm = 1'b1;
        lk = 0; adm = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 1) confirm = 1'b0;
            if (c == 10) begin pass_idx = 2'b10; confirm = 1'b1; end
            if (c == 12) confirm = 1'b0;
            if (locked) lk++;
            if (admin_mode) adm++;
        end
        check("lockout_len", lk, LCK);
        check("lockout_ignored", adm, 0);
        check("lockout_end", locked, 0);
        pass_idx = 2'b01;
        press_n(2, 2);
        check("fail_cleared", locked, 0);
        pass_idx = 2'b10;
        press(2);
        check("login_after_lock", admin_mode, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
